// File: rtl/wb_leds_pwm.sv
// wb_leds_pwm: Wishbone LED bank with per-channel 8-bit PWM brightness and a shared prescaled timebase.
// Optional blink timer enabled by defining WB_LEDS_PWM_BLINK_EN.
module wb_leds_pwm #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ABITS    = 4,
    parameter bit HIGHZ    = 1'b0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [ABITS-1:0]    wb_adr_i,
    input  logic [WIDTH/8-1:0]  wb_sel_i,
    input  logic [WIDTH-1:0]    wb_dat_i,
    output logic                wb_ack_o,
    output logic [WIDTH/8-1:0]  wb_sel_o,
    output logic [WIDTH-1:0]    wb_dat_o,
    output logic [CHANNELS-1:0] leds_o
);
    logic                r_ack;
    logic [7:0]          r_dat;
    logic [WIDTH/8-1:0]  r_sel;
    logic                r_en, r_inv;
    logic [7:0]          r_prescale, r_pre_cnt, r_pwm_cnt;
    logic [7:0]          r_duty   [CHANNELS];
    logic [7:0]          r_shadow [CHANNELS];
    logic [CHANNELS-1:0] r_leds;
    logic                w_start, w_wr, w_tick, w_pend, w_blink_on, w_ctl_blink;
    logic [7:0]          w_wdat, w_blink_reg, w_rdata;
    logic [31:0]         w_adr;
    logic                w_unused;

    assign w_start  = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr     = w_start & wb_we_i & wb_sel_i[0];
    assign w_wdat   = wb_dat_i[7:0];
    assign w_adr    = 32'(wb_adr_i);
    assign w_tick   = r_en & (r_pre_cnt >= r_prescale);
    assign w_pend   = w_tick & (r_pwm_cnt == 8'd254);
    assign w_unused = ^wb_dat_i;

`ifdef WB_LEDS_PWM_BLINK_EN
    logic       r_ctl_blink, r_blink_on;
    logic [7:0] r_blink, r_blk_cnt;
    logic [7:0] w_blk_max;
    logic       w_blk_done;

    assign w_blk_max   = (r_blink == 8'd0) ? 8'd1 : r_blink;
    assign w_blk_done  = (r_blk_cnt + 8'd1) >= w_blk_max;
    assign w_ctl_blink = r_ctl_blink;
    assign w_blink_reg = r_blink;
    assign w_blink_on  = r_blink_on;

    // Blink control bit and period register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            r_ctl_blink <= 1'b0;
            r_blink     <= 8'd0;
        end else if (w_wr) begin
            if (w_adr == 32'd0) r_ctl_blink <= w_wdat[2];
            if (w_adr == 32'd2) r_blink <= w_wdat;
        end

    // Blink timer: toggle after max(BLINK,1) PWM periods; held on while disabled
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            r_blk_cnt  <= 8'd0;
            r_blink_on <= 1'b1;
        end else if (!r_en || !r_ctl_blink) begin
            r_blk_cnt  <= 8'd0;
            r_blink_on <= 1'b1;
        end else if (w_pend) begin
            r_blk_cnt  <= w_blk_done ? 8'd0 : r_blk_cnt + 8'd1;
            r_blink_on <= w_blk_done ? ~r_blink_on : r_blink_on;
        end
`else
    assign w_ctl_blink = 1'b0;
    assign w_blink_reg = 8'd0;
    assign w_blink_on  = 1'b1;
`endif

    // Read mux; unmapped and reserved addresses read as zero
    always_comb begin
        w_rdata = 8'd0;
        if (w_adr == 32'd0) w_rdata = {5'd0, w_ctl_blink, r_inv, r_en};
        if (w_adr == 32'd1) w_rdata = r_prescale;
        if (w_adr == 32'd2) w_rdata = w_blink_reg;
        for (int n = 0; n < CHANNELS; n++)
            if (w_adr == 32'(4 + n)) w_rdata = r_duty[n];
    end

    // Bus handshake: single-cycle ack, read data and select echo registered with it
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= 8'd0;
            r_sel <= '0;
        end else begin
            r_ack <= w_start;
            r_dat <= w_start ? w_rdata : 8'd0;
            r_sel <= w_start ? wb_sel_i : '0;
        end

    // Control, prescale and duty registers written on the acking edge
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            r_en       <= 1'b0;
            r_inv      <= 1'b0;
            r_prescale <= 8'd0;
            for (int n = 0; n < CHANNELS; n++) r_duty[n] <= 8'd0;
        end else if (w_wr) begin
            if (w_adr == 32'd0) begin
                r_en  <= w_wdat[0];
                r_inv <= w_wdat[1];
            end
            if (w_adr == 32'd1) r_prescale <= w_wdat;
            for (int n = 0; n < CHANNELS; n++)
                if (w_adr == 32'(4 + n)) r_duty[n] <= w_wdat;
        end

    // Shared timebase: >= compare lets a lowered prescale tick at once instead of wrapping
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            r_pre_cnt <= 8'd0;
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pre_cnt <= (!r_en || w_tick) ? 8'd0 : r_pre_cnt + 8'd1;
            r_pwm_cnt <= !r_en ? 8'd0 : !w_tick ? r_pwm_cnt : (r_pwm_cnt == 8'd254) ? 8'd0 : r_pwm_cnt + 8'd1;
        end

    // Shadow duties reload only at period end (or continuously while disabled), new write wins
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            for (int n = 0; n < CHANNELS; n++) r_shadow[n] <= 8'd0;
        end else begin
            for (int n = 0; n < CHANNELS; n++)
                if (!r_en || w_pend) r_shadow[n] <= (w_wr && w_adr == 32'(4 + n)) ? w_wdat : r_duty[n];
        end

    // Registered LED drive with blink gating and polarity inversion
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            r_leds <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++)
                r_leds[n] <= (r_en & (r_pwm_cnt < r_shadow[n]) & w_blink_on) ^ r_inv;
        end

    assign wb_ack_o = r_ack;
    assign wb_sel_o = (HIGHZ && !r_ack) ? {(WIDTH/8){1'bz}} : r_sel;
    assign wb_dat_o = (HIGHZ && !r_ack) ? {WIDTH{1'bz}} : WIDTH'(r_dat);
    assign leds_o   = r_leds;
endmodule
